// File: rtl/quiz_pkg.sv
// Shared types for the quiz round controller: state codes and judge result encodings.
package quiz_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ASK    = 4'd2,
        ST_ANSWER = 4'd3,
        ST_JUDGE  = 4'd4,
        ST_DAMAGE = 4'd5,
        ST_NEXT   = 4'd6,
        ST_CLEAR  = 4'd7,
        ST_OVER   = 4'd8
    } state_e;

    localparam logic [1:0] JUDG_NONE = 2'b00;
    localparam logic [1:0] JUDG_OK   = 2'b01;
    localparam logic [1:0] JUDG_NG   = 2'b10;

endpackage

// File: rtl/answer_timer.sv
// Loadable down-counter for the per-question answer window; stops at zero.
module answer_timer #(
    parameter int TMR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic [TMR_W-1:0] cnt,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign zero = (cnt_q == '0);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round controller for the factorization game: question sequencing, HP pool,
// correct-answer count and per-question answer timer.
//
// state  | meaning
// IDLE   | waiting for player ready
// START  | load HP, clear count
// ASK    | requesting a question from the generator
// ANSWER | answer window running
// JUDGE  | count a correct answer
// DAMAGE | take one hit point
// NEXT   | wait for judge/generator to release
// CLEAR  | round won, wait for OK
// OVER   | out of HP, wait for OK
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int HP_W       = 2,
    parameter int NUM_Q      = 8,
    parameter int TIME_LIMIT = 1000,
    parameter int TMR_W      = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            READY_IN,
    input  logic            OK_IN,
    input  logic [HP_W-1:0] HP_IN,
    input  logic            QUE_IN,
    input  logic [1:0]      JUDG_IN,
    input  logic            WRONG_IN,
    output logic            READY_OUT,
    output logic            QUE_REQ,
    output logic [3:0]      STATE,
    output logic [HP_W-1:0] HP_OUT,
    output logic [7:0]      Q_CNT,
    output logic [TMR_W-1:0] TMR_OUT,
    output logic            CLEAR_OUT,
    output logic            OVER_OUT
);

    localparam logic [7:0]       NUM_Q_C    = 8'(NUM_Q);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIME_LIMIT - 1);

    state_e          state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [7:0]      q_cnt_q, q_cnt_d;
    logic [7:0]      q_cnt_inc;
    logic [HP_W-1:0] hp_dec;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;

    assign q_cnt_inc = q_cnt_q + 8'd1;
    assign hp_dec    = (hp_q == '0) ? '0 : hp_q - HP_W'(1);

    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        q_cnt_d  = q_cnt_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (READY_IN) state_d = ST_START;
            end
            ST_START: begin
                hp_d    = HP_IN;
                q_cnt_d = '0;
                state_d = (HP_IN == '0) ? ST_OVER : ST_ASK;
            end
            ST_ASK: begin
                if (QUE_IN) begin
                    tmr_load = 1'b1;
                    state_d  = ST_ANSWER;
                end
            end
            ST_ANSWER: begin
                // A correct verdict beats both a forced penalty and a same-cycle timeout.
                tmr_dec = 1'b1;
                if (JUDG_IN == JUDG_OK) begin
                    state_d = ST_JUDGE;
                end else if (JUDG_IN[1] || WRONG_IN) begin
                    state_d = ST_DAMAGE;
                end else if (tmr_zero) begin
                    state_d = ST_DAMAGE;
                end
            end
            ST_JUDGE: begin
                q_cnt_d = q_cnt_inc;
                state_d = (q_cnt_inc == NUM_Q_C) ? ST_CLEAR : ST_NEXT;
            end
            ST_DAMAGE: begin
                hp_d    = hp_dec;
                state_d = (hp_dec == '0) ? ST_OVER : ST_NEXT;
            end
            ST_NEXT: begin
                if ((JUDG_IN == JUDG_NONE) && !QUE_IN) state_d = ST_ASK;
            end
            ST_CLEAR, ST_OVER: begin
                if (OK_IN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            hp_q    <= '0;
            q_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            q_cnt_q <= q_cnt_d;
        end
    end

    answer_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .load    (tmr_load),
        .load_val(TMR_RELOAD),
        .dec     (tmr_dec),
        .cnt     (TMR_OUT),
        .zero    (tmr_zero)
    );

    assign STATE     = state_q;
    assign READY_OUT = (state_q == ST_IDLE);
    assign QUE_REQ   = (state_q == ST_ASK);
    assign CLEAR_OUT = (state_q == ST_CLEAR);
    assign OVER_OUT  = (state_q == ST_OVER);
    assign HP_OUT    = hp_q;
    assign Q_CNT     = q_cnt_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed round scenarios with literal expectations,
// then random stimulus, all shadowed by a cycle-level behavioural model.
module tb_quiz_round_ctrl;

    localparam int HP_W       = 2;
    localparam int NUM_Q      = 2;
    localparam int TIME_LIMIT = 16;
    localparam int TMR_W      = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             READY_IN = 1'b0;
    logic             OK_IN = 1'b0;
    logic [HP_W-1:0]  HP_IN = '0;
    logic             QUE_IN = 1'b0;
    logic [1:0]       JUDG_IN = 2'b00;
    logic             WRONG_IN = 1'b0;
    logic             READY_OUT;
    logic             QUE_REQ;
    logic [3:0]       STATE;
    logic [HP_W-1:0]  HP_OUT;
    logic [7:0]       Q_CNT;
    logic [TMR_W-1:0] TMR_OUT;
    logic             CLEAR_OUT;
    logic             OVER_OUT;

    quiz_round_ctrl #(
        .HP_W(HP_W), .NUM_Q(NUM_Q), .TIME_LIMIT(TIME_LIMIT), .TMR_W(TMR_W)
    ) dut (
        .CLK(CLK), .RST(RST), .READY_IN(READY_IN), .OK_IN(OK_IN), .HP_IN(HP_IN),
        .QUE_IN(QUE_IN), .JUDG_IN(JUDG_IN), .WRONG_IN(WRONG_IN),
        .READY_OUT(READY_OUT), .QUE_REQ(QUE_REQ), .STATE(STATE), .HP_OUT(HP_OUT),
        .Q_CNT(Q_CNT), .TMR_OUT(TMR_OUT), .CLEAR_OUT(CLEAR_OUT), .OVER_OUT(OVER_OUT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state codes as numbers, answer timer as cycles spent answering.
    int m_st  = 0;
    int m_hp  = 0;
    int m_q   = 0;
    int m_tmr = 0;
    int m_n   = 0;
    bit m_valid = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_st <= 0; m_hp <= 0; m_q <= 0; m_tmr <= 0; m_n <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_st)
                0: if (READY_IN) m_st <= 1;
                1: begin
                    m_hp <= int'(HP_IN);
                    m_q  <= 0;
                    m_st <= (HP_IN == 0) ? 8 : 2;
                end
                2: if (QUE_IN) begin
                    m_st  <= 3;
                    m_n   <= 0;
                    m_tmr <= TIME_LIMIT - 1;
                end
                3: begin
                    m_n   <= m_n + 1;
                    m_tmr <= (TIME_LIMIT - 1 - m_n > 0) ? TIME_LIMIT - 2 - m_n : 0;
                    if (JUDG_IN == 2'b01)                       m_st <= 4;
                    else if (JUDG_IN >= 2'b10 || WRONG_IN)      m_st <= 5;
                    else if (m_n == TIME_LIMIT - 1)             m_st <= 5;
                end
                4: begin
                    m_q  <= m_q + 1;
                    m_st <= (m_q + 1 == NUM_Q) ? 7 : 6;
                end
                5: begin
                    m_hp <= (m_hp > 0) ? m_hp - 1 : 0;
                    m_st <= (m_hp <= 1) ? 8 : 6;
                end
                6: if (JUDG_IN == 2'b00 && !QUE_IN) m_st <= 2;
                7, 8: if (OK_IN) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            check("state",     32'(STATE),     32'(m_st));
            check("ready_out", 32'(READY_OUT), 32'(m_st == 0));
            check("que_req",   32'(QUE_REQ),   32'(m_st == 2));
            check("clear_out", 32'(CLEAR_OUT), 32'(m_st == 7));
            check("over_out",  32'(OVER_OUT),  32'(m_st == 8));
            check("hp_out",    32'(HP_OUT),    32'(m_hp));
            check("q_cnt",     32'(Q_CNT),     32'(m_q));
            check("tmr_out",   32'(TMR_OUT),   32'(m_tmr));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go_ask(input int hp);
        HP_IN = HP_W'(hp);
        READY_IN = 1'b1;
        tick();
        READY_IN = 1'b0;
        tick();
    endtask

    // ASK -> ANSWER -> JUDGE/DAMAGE -> following state, with the given verdict.
    task automatic answer(input logic [1:0] verdict);
        QUE_IN = 1'b1;
        tick();
        QUE_IN = 1'b0;
        JUDG_IN = verdict;
        tick();
        JUDG_IN = 2'b00;
        tick();
    endtask

    int r;

    initial begin
        tick();
        tick();
        check("rst_state", 32'(STATE), 0);
        check("rst_ready", 32'(READY_OUT), 1);
        check("rst_vals", 32'({QUE_REQ, HP_OUT, Q_CNT, TMR_OUT, CLEAR_OUT, OVER_OUT}), 0);
        RST = 1'b0;

        HP_IN = 2'd3;
        READY_IN = 1'b1;
        tick();
        check("start_state", 32'(STATE), 1);
        READY_IN = 1'b0;
        tick();
        check("ask_state", 32'(STATE), 2);
        check("ask_hp", 32'(HP_OUT), 3);
        check("ask_que_req", 32'(QUE_REQ), 1);

        answer(2'b01);
        check("c1_state", 32'(STATE), 6);
        check("c1_q", 32'(Q_CNT), 1);
        tick();
        answer(2'b01);
        check("clear_state", 32'(STATE), 7);
        check("clear_q", 32'(Q_CNT), 2);
        check("clear_out", 32'(CLEAR_OUT), 1);
        OK_IN = 1'b1;
        tick();
        OK_IN = 1'b0;
        check("clear_ok_idle", 32'(STATE), 0);

        go_ask(2);
        answer(2'b10);
        check("w1_hp", 32'(HP_OUT), 1);
        check("w1_state", 32'(STATE), 6);
        tick();
        answer(2'b11);
        check("w2_hp", 32'(HP_OUT), 0);
        check("over_state", 32'(STATE), 8);
        check("over_out", 32'(OVER_OUT), 1);
        OK_IN = 1'b1;
        tick();
        OK_IN = 1'b0;

        go_ask(3);
        QUE_IN = 1'b1;
        tick();
        QUE_IN = 1'b0;
        check("to_tmr_start", 32'(TMR_OUT), 15);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_still_answer", 32'(STATE), 3);
        end
        check("to_tmr_zero", 32'(TMR_OUT), 0);
        tick();
        check("to_damage_at_16", 32'(STATE), 5);
        tick();
        check("to_hp", 32'(HP_OUT), 2);
        tick();

        QUE_IN = 1'b1;
        tick();
        QUE_IN = 1'b0;
        repeat (15) tick();
        check("jz_tmr_zero", 32'(TMR_OUT), 0);
        JUDG_IN = 2'b01;
        tick();
        JUDG_IN = 2'b00;
        check("jz_judge", 32'(STATE), 4);
        tick();
        check("jz_hp_kept", 32'(HP_OUT), 2);
        check("jz_q", 32'(Q_CNT), 1);
        tick();

        QUE_IN = 1'b1;
        tick();
        QUE_IN = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_state", 32'(STATE), 0);
        check("mid_rst_ready", 32'(READY_OUT), 1);
        check("mid_rst_vals", 32'({QUE_REQ, HP_OUT, Q_CNT, TMR_OUT, CLEAR_OUT, OVER_OUT}), 0);

        go_ask(0);
        check("hp0_over", 32'(STATE), 8);
        OK_IN = 1'b1;
        tick();
        OK_IN = 1'b0;

        go_ask(1);
        QUE_IN = 1'b1;
        tick();
        QUE_IN = 1'b0;
        JUDG_IN = 2'b01;
        WRONG_IN = 1'b1;
        tick();
        JUDG_IN = 2'b00;
        WRONG_IN = 1'b0;
        check("ok_and_wrong_judge", 32'(STATE), 4);
        tick();
        check("ok_and_wrong_hp", 32'(HP_OUT), 1);

        repeat (3000) begin
            RST      = ($urandom_range(0, 299) == 0);
            READY_IN = ($urandom_range(0, 3) == 0);
            OK_IN    = ($urandom_range(0, 3) == 0);
            HP_IN    = HP_W'($urandom_range(0, 3));
            QUE_IN   = ($urandom_range(0, 2) == 0);
            WRONG_IN = ($urandom_range(0, 15) == 0);
            r = int'($urandom_range(0, 9));
            JUDG_IN  = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            tick();
        end

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Parametrised round controller for the factorization game. It replaces the fixed four-state control block with:

- a configurable number of questions per round;
- a hit-point pool of configurable width;
- a per-question answer timer with timeout-as-wrong;
- explicit clear/game-over terminal states.

It sits between the ready/OK button conditioning, the question generator, the answer judge, and the display/LED logic that consumes `STATE`.

## Interface
- `HP_W`, 2 — width of the hit-point counter and the `HP_IN` load value.
- `NUM_Q`, 8 — correct answers required to clear a round (1..255).
- `TIME_LIMIT`, 1000 — answer window per question in `CLK` cycles (≥2).
- `TMR_W`, 10 — timer width; must satisfy 2^`TMR_W` > `TIME_LIMIT`.

Ports:
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — synchronous, active-high reset.
- `READY_IN` in 1 — player start request, level.
- `OK_IN` in 1 — acknowledge, leaves CLEAR/OVER.
- `HP_IN` in `HP_W` — starting hit points, sampled at round start.
- `QUE_IN` in 1 — generator: question valid.
- `JUDG_IN` in 2 — judge result: 00 pending, 01 correct, 10 wrong, 11 treated as wrong.
- `WRONG_IN` in 1 — forced penalty (e.g. illegal key), level.
- `READY_OUT` out 1 — high in IDLE only.
- `QUE_REQ` out 1 — question request to generator.
- `STATE` out 4 — current state encoding.
- `HP_OUT` out `HP_W` — remaining hit points.
- `Q_CNT` out 8 — correct answers this round.
- `TMR_OUT` out `TMR_W` — remaining answer cycles.
- `CLEAR_OUT` out 1 — high in CLEAR.
- `OVER_OUT` out 1 — high in OVER.

## Operation
- States and codes: IDLE=0, START=1, ASK=2, ANSWER=3, JUDGE=4, DAMAGE=5, NEXT=6, CLEAR=7, OVER=8. Codes 9–15 are illegal and go to IDLE next cycle.
- IDLE → START: when `READY_IN`=1.
- START: load `HP_OUT`←`HP_IN` and `Q_CNT`←0.
  - If `HP_IN`=0, go to OVER.
  - Otherwise go to ASK.
- ASK:
  - `QUE_REQ`=1.
  - Stay until `QUE_IN`=1, then load `TMR_OUT`←`TIME_LIMIT`−1 and go to ANSWER.
- ANSWER: `TMR_OUT` decrements each cycle. Exits are checked in this priority order:
  1. `JUDG_IN`=01 → JUDGE.
  2. `JUDG_IN`∈{10,11} or `WRONG_IN`=1 → DAMAGE.
  3. `TMR_OUT`=0 → DAMAGE (timeout).
- JUDGE:
  - `Q_CNT`+1.
  - If the new count = `NUM_Q`, go to CLEAR; else go to NEXT.
- DAMAGE:
  - `HP_OUT`−1, saturating at 0.
  - If the new value = 0, go to OVER; else go to NEXT.
- NEXT: wait until `JUDG_IN`=00 and `QUE_IN`=0 (judge/generator released), then go to ASK.
- CLEAR / OVER: hold all counters; on `OK_IN`=1 go to IDLE.
- `READY_IN` and `OK_IN` are ignored outside the states named above.

## Timing
- Reset values: `STATE`=IDLE(0), `READY_OUT`=1, `QUE_REQ`=0, `HP_OUT`=0, `Q_CNT`=0, `TMR_OUT`=0, `CLEAR_OUT`=0, `OVER_OUT`=0.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Latency:
  - `READY_IN` to ASK: 2 cycles.
  - Correct answer to next `QUE_REQ`: 3 cycles minimum (JUDGE, NEXT, ASK).
- A judge result arriving in the same cycle as `TMR_OUT`=0 wins over the timeout.
- `JUDG_IN`=01 together with `WRONG_IN`=1 counts as correct.
- Timeout fires exactly `TIME_LIMIT` cycles after entering ANSWER.
- `RST` mid-round returns to IDLE on the next edge, discarding HP and count.

## Structure
- Shared package `quiz_pkg` holds:
  - the state enum and 4-bit codes;
  - the `JUDG_IN` encodings (`JUDG_NONE`, `JUDG_OK`, `JUDG_NG`).
- One sub-module, `answer_timer`: loadable down-counter with a zero flag, width `TMR_W`.
- FSM and the HP/`Q_CNT` counters stay in the top module.

## Test plan
- Reset, then `READY_IN`=1 with `HP_IN`=3 → `STATE` 0→1→2, `HP_OUT`=3, `QUE_REQ`=1.
- `NUM_Q`=2, two correct judges → `Q_CNT`=2, `STATE`=7, `CLEAR_OUT`=1; then `OK_IN` → IDLE.
- `HP_IN`=2, two wrong judges → `HP_OUT` 2→1→0, `STATE`=8, `OVER_OUT`=1.
- `TIME_LIMIT`=16, no judge → DAMAGE entered exactly 16 cycles after ANSWER entry; `HP_OUT` decremented.
- `JUDG_IN`=01 on the cycle `TMR_OUT`=0 → JUDGE, HP unchanged.
- `RST` asserted in ANSWER with `Q_CNT`=1 → next cycle `STATE`=0, all outputs at reset values; `HP_IN`=0 start → OVER directly.
